// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample types and defaults for the streamer and the DAC side.
package audio_pkg;
    localparam int AUDIO_WIDTH       = 4;
    localparam int AUDIO_SAMPLE_TIME = 656;
    localparam int AUDIO_DEPTH       = 8;
    typedef struct packed {
        logic [AUDIO_WIDTH-1:0] left;
        logic [AUDIO_WIDTH-1:0] right;
    } stereo_sample_t;
endpackage

// File: rtl/audio_sample_streamer_if.sv
// audio_sample_streamer_if: upstream pair handshake plus the DAC-facing sample outputs.
interface audio_sample_streamer_if #(
    parameter int WIDTH = audio_pkg::AUDIO_WIDTH,
    parameter int DEPTH = audio_pkg::AUDIO_DEPTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_left;
    logic [WIDTH-1:0]       in_right;
    logic [WIDTH-1:0]       left_out;
    logic [WIDTH-1:0]       right_out;
    logic                   sample_strobe;
    logic                   underrun;
    logic [$clog2(DEPTH):0] level;
    modport master (
        output in_valid, in_left, in_right,
        input  in_ready, left_out, right_out, sample_strobe, underrun, level
    );
    modport slave (
        input  in_valid, in_left, in_right,
        output in_ready, left_out, right_out, sample_strobe, underrun, level
    );
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: DEPTH x W FIFO with combinational head and an occupancy counter.
module sample_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    assign head = mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            level <= (push && !pop) ? level + LW'(1) : (!push && pop) ? level - LW'(1) : level;
        end
endmodule

// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: buffers stereo pairs and emits one every SAMPLE_TIME clocks; AUDIO_STREAMER_HOLD_ON_UNDERRUN_EN holds outputs on underrun.
module audio_sample_streamer
    import audio_pkg::*;
#(
    parameter int WIDTH       = AUDIO_WIDTH,
    parameter int SAMPLE_TIME = AUDIO_SAMPLE_TIME,
    parameter int DEPTH       = AUDIO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    audio_sample_streamer_if.slave s
);
    localparam int CW = $clog2(SAMPLE_TIME);
    localparam int LW = $clog2(DEPTH) + 1;
    logic [CW-1:0]      tick;
    logic [2*WIDTH-1:0] head;
    logic               pop_evt, empty, push;
    assign empty      = s.level == '0;
    assign s.in_ready = rst_n && s.level != LW'(DEPTH);
    assign push       = s.in_valid && s.in_ready;
    assign pop_evt    = tick == CW'(SAMPLE_TIME - 1);
    sample_fifo #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop_evt && !empty),
        .din   ({s.in_left, s.in_right}),
        .head  (head),
        .level (s.level)
    );
    // An empty FIFO at a pop event never exposes the stale head; a pair pushed that cycle waits for the next strobe.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tick            <= '0;
            s.left_out      <= '0;
            s.right_out     <= '0;
            s.sample_strobe <= 1'b0;
            s.underrun      <= 1'b0;
        end else begin
            tick            <= pop_evt ? '0 : tick + CW'(1);
            s.sample_strobe <= pop_evt;
            s.underrun      <= pop_evt && empty;
            if (pop_evt && !empty) {s.left_out, s.right_out} <= head;
`ifndef AUDIO_STREAMER_HOLD_ON_UNDERRUN_EN
            else if (pop_evt) {s.left_out, s.right_out} <= '0;
`endif
        end
endmodule
